niosmp_async_rx: RTL
====================

// Module: niosmp_async_rx
// PURPOSE
//  Asynchronous serial byte receiver for the AsynComms link; the stage directly upstream of the
//  niosmp_chrec PIO. Oversamples the raw rx line, deserialises 8N1 frames (LSB first), holds the
//  byte, and drives a level "character received" flag into chrec.in_port until software acks it.
//  Software reads rx_data via a data PIO and pulses rx_ack via an output PIO.
// PARAMETERS
//  CLK_DIV    16  clk cycles per bit period (>=4, even); production 5208 (50 MHz / 9600 baud)
//  DATA_BITS  8   data bits per frame (fixed 8 in this release; width of rx_data)
// PORTS
//  clk            in   1  system clock
//  reset_n        in   1  reset
//  rx_serial      in   1  raw async serial line, idle high, not synchronous to clk
//  rx_ack         in   1  software ack level from output PIO; rising edge clears flags
//  rx_data        out  8  last good received byte
//  char_received  out  1  byte waiting; feeds niosmp_chrec in_port
//  framing_err    out  1  sticky: stop bit sampled low
//  overrun        out  1  sticky: good byte completed while char_received already 1
//  parity_err     out  1  sticky parity mismatch (tied 0 without ASYNC_RX_PARITY_EN)
// BEHAVIOUR
//  Reset: reset reset_n, asynchronous, active-low; clock clk. On reset: FSM=IDLE, sync flops=1,
//   rx_ack edge flop=0, bit/baud counters=0, all outputs 0. Reset mid-frame aborts frame, no flags.
//  rx_serial passes 2-FF synchroniser (rxs); all decisions use rxs only.
//  rx_ack: registered; ack_rise = rx_ack & ~rx_ack_q. One-cycle pulse internally.
//  Baud counter counts 0..CLK_DIV-1, restarted on each state entry.
//  FSM:
//   IDLE  : rxs==0 -> START, counter cleared.
//   START : at count CLK_DIV/2-1 sample rxs; 0 -> DATA (bit_idx=0); 1 -> IDLE (glitch rejected).
//   DATA  : every CLK_DIV cycles (mid-bit) shift rxs into shreg[bit_idx], LSB first;
//           after bit 7 -> PARITY if macro defined, else STOP.
//   PARITY: sample mid-bit; store even-parity check result; -> STOP.
//   STOP  : sample mid-bit; -> IDLE on same cycle (next start edge detected half a bit early is OK).
//  Stop sample results (registered, visible the cycle after the mid-stop sample):
//   rxs==0            -> framing_err<=1; rx_data, char_received unchanged.
//   parity mismatch   -> parity_err<=1;  rx_data, char_received unchanged.
//   good, flag==0     -> rx_data<=shreg; char_received<=1.
//   good, flag==1     -> overrun<=1; rx_data NOT overwritten (first byte kept).
//  ack_rise clears char_received, framing_err, overrun, parity_err.
//  Simultaneous ack_rise and good completion: clear applied first -> rx_data<=new byte,
//   char_received=1, overrun=0; error flags cleared.
//  Simultaneous ack_rise and bad completion: flags cleared, then new error flag set.
//  Latency: char_received rises 2 (sync) + CLK_DIV/2 + 9*CLK_DIV + 1 cycles after the line's
//   start edge (+CLK_DIV with parity), +-1 cycle for sync phase.
//  rx_ack held high does not re-clear; only rising edges act.
// CONFIGURATION
//  ASYNC_RX_PARITY_EN defined: frame is 8E1; PARITY state inserted; even parity over 8 data bits
//   plus parity bit must be 0, else parity_err set and byte discarded.
//  Not defined: frame 8N1, no PARITY state, parity_err driven constant 0.
// TESTING (CLK_DIV=16, bit = 16 clk)
//  8N1 byte 0x55, stop=1 -> rx_data=0x55, char_received=1 within 2+8+144+1 (+-1) clks of start edge.
//  rx_serial low for 4 clk then high -> FSM returns IDLE, no flag/data change.
//  0xA3 with stop bit=0 -> framing_err=1, char_received=0, rx_data keeps previous value.
//  0x12 then 0x34, no ack -> rx_data=0x12, overrun=1; rx_ack 0->1 -> all flags 0, rx_data=0x12.
//  reset_n low during DATA bit 3, release, send 0x7E -> outputs 0 during reset; then rx_data=0x7E.
//  ASYNC_RX_PARITY_EN: 0x01 with parity bit 0 -> parity_err=1, char_received=0; parity 1 -> ok.

Source files
------------

// File: rtl/niosmp_async_rx.sv
// Oversampling async serial receiver (8N1, or 8E1 when ASYNC_RX_PARITY_EN is defined) feeding niosmp_chrec.
// Holds the last good byte and a level "character received" flag until software acks it with a rising edge.
module niosmp_async_rx #(
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_serial,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 char_received,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 char_next, fe_next, ov_next;
    logic                 rx_meta, rxs;
    logic                 rx_ack_q, ack_rise;

    // rx_serial is asynchronous to clk; only rxs is used downstream
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rx_ack_q <= 1'b0;
        end else begin
            rx_meta  <= rx_serial;
            rxs      <= rx_meta;
            rx_ack_q <= rx_ack;
        end
    end

    assign ack_rise = rx_ack & ~rx_ack_q;

`ifdef ASYNC_RX_PARITY_EN
    logic par_bad, par_bad_next, pe_next;
`else
    assign parity_err = 1'b0;
`endif

    // Next-state, datapath and flag logic; ack clear is applied before any completion update
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        data_next    = rx_data;
        char_next    = char_received & ~ack_rise;
        fe_next      = framing_err & ~ack_rise;
        ov_next      = overrun & ~ack_rise;
`ifdef ASYNC_RX_PARITY_EN
        pe_next      = parity_err & ~ack_rise;
        par_bad_next = par_bad;
`endif
        case (state)
            IDLE: begin
                if (!rxs) state_next = START;
            end
            START: begin
                bit_idx_next = '0;
                if (cnt == HALF_LAST) state_next = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    shreg_next[bit_idx] = rxs;
                    bit_idx_next        = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_LAST) begin
`ifdef ASYNC_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef ASYNC_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL_LAST) begin
                    par_bad_next = ^{shreg, rxs};
                    state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL_LAST) begin
                    state_next = IDLE;
                    if (!rxs) begin
                        fe_next = 1'b1;
                    end
`ifdef ASYNC_RX_PARITY_EN
                    else if (par_bad) begin
                        pe_next = 1'b1;
                    end
`endif
                    else if (char_next) begin
                        ov_next = 1'b1;
                    end else begin
                        data_next = shreg;
                        char_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // baud counter restarts on every state entry and wraps each bit period
        cnt_next = (state_next != state || cnt == FULL_LAST) ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_data       <= '0;
            char_received <= 1'b0;
            framing_err   <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            bit_idx       <= bit_idx_next;
            shreg         <= shreg_next;
            rx_data       <= data_next;
            char_received <= char_next;
            framing_err   <= fe_next;
            overrun       <= ov_next;
        end
    end

`ifdef ASYNC_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_next;
            parity_err <= pe_next;
        end
    end
`endif

endmodule
